// File: rtl/kyber_coeff_decompress.sv
// Kyber coefficient decompression: unpacks 256 D-bit coefficients into 12-bit values mod q, LANES per cycle.
// Optional macro KYBER_DECOMP_BUSY_EN adds a 'busy' output that is high while the unit is in RUN.
module kyber_coeff_decompress #(
  parameter int D_BITS  = 10,
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int COEF_W  = 12,
  parameter int LANES   = 8,
  parameter int IN_W    = D_BITS * KYBER_N
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [IN_W-1:0]             i_compressed,
  output logic                        done,
  output logic [COEF_W*KYBER_N-1:0]   o_poly
`ifdef KYBER_DECOMP_BUSY_EN
  ,
  output logic                        busy
`endif
);

  localparam int G     = KYBER_N / LANES;
  localparam int IDX_W = (G > 1) ? $clog2(G) : 1;
  localparam int PW    = D_BITS + COEF_W + 1;

  localparam logic [IDX_W-1:0] LAST_GRP = IDX_W'(G - 1);
  localparam logic [PW-1:0]    Q_EXT    = PW'(KYBER_Q);
  localparam logic [PW-1:0]    ROUND    = PW'(1) << (D_BITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Handshake: enable is a level request sampled in IDLE; done pulses one cycle when o_poly is complete,
  // and a still-high enable is absorbed in HOLD so it cannot retrigger a run.

  logic [1:0]       state;
  logic [IDX_W-1:0] grp_idx;
  logic [IN_W-1:0]  stream_in;
  logic [IN_W-1:0]  stream_q;
  logic [D_BITS-1:0] lane_x [LANES];
  logic [COEF_W-1:0] lane_y [LANES];

  function automatic logic [COEF_W-1:0] decomp(input logic [D_BITS-1:0] x);
    return COEF_W'(((PW'(x) * Q_EXT) + ROUND) >> D_BITS);
  endfunction

  // Byte j sits at the top of the bus first; re-order into a little-endian bitstream once at latch time.
  for (genvar s = 0; s < IN_W; s++) begin : g_reorder
    assign stream_in[s] = i_compressed[IN_W - 8 - 8 * (s / 8) + (s % 8)];
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_x[l] = stream_q[(int'(grp_idx) * LANES + l) * D_BITS +: D_BITS];
      lane_y[l] = decomp(lane_x[l]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      grp_idx  <= '0;
      stream_q <= '0;
      o_poly   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            stream_q <= stream_in;
            grp_idx  <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++) begin
            o_poly[(int'(grp_idx) * LANES + l) * COEF_W +: COEF_W] <= lane_y[l];
          end
          if (grp_idx == LAST_GRP) begin
            grp_idx <= '0;
            done    <= 1'b1;
            state   <= HOLD;
          end else begin
            grp_idx <= grp_idx + 1'b1;
          end
        end
        HOLD: begin
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KYBER_DECOMP_BUSY_EN
  assign busy = (state == RUN);
`endif

endmodule

// File: tb/tb_kyber_coeff_decompress.sv
// Bench for kyber_coeff_decompress: one D=3 and one D=10 instance, table vectors, random vectors and corner sequences.
module tb_kyber_coeff_decompress;

  localparam int PW_W = 12 * 256;
  localparam int G    = 32;

  typedef struct {
    bit           d10;
    logic [2559:0] comp;
    int           sel_idx;
    logic [11:0]  sel_val;
    logic [11:0]  rest_val;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic en3, en10;
  logic [767:0]  comp3;
  logic [2559:0] comp10;
  logic done3, done10;
  logic [PW_W-1:0] poly3, poly10;
`ifdef KYBER_DECOMP_BUSY_EN
  logic busy3, busy10;
`endif

  logic [PW_W-1:0] exp_q3[$];
  logic [PW_W-1:0] exp_q10[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  kyber_coeff_decompress #(.D_BITS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable(en3), .i_compressed(comp3),
    .done(done3), .o_poly(poly3)
`ifdef KYBER_DECOMP_BUSY_EN
    , .busy(busy3)
`endif
  );

  kyber_coeff_decompress #(.D_BITS(10)) dut10 (
    .clk(clk), .reset_n(reset_n), .enable(en10), .i_compressed(comp10),
    .done(done10), .o_poly(poly10)
`ifdef KYBER_DECOMP_BUSY_EN
    , .busy(busy10)
`endif
  );

  task automatic chk_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic chk_poly(input string name, input logic [PW_W-1:0] act, input logic [PW_W-1:0] exp);
    int first;
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      first = -1;
      for (int i = 255; i >= 0; i--) if (act[12*i +: 12] !== exp[12*i +: 12]) first = i;
      $display("FAIL %s: coef %0d got %0d want %0d", name, first,
               act[12*first +: 12], exp[12*first +: 12]);
    end
  endtask

  // Reference: walk the byte/bitstream layout bit by bit and apply the rounding formula directly.
  function automatic logic [PW_W-1:0] model(input bit d10, input logic [2559:0] comp);
    logic [PW_W-1:0] res;
    int d, inw, x, y, s;
    d = d10 ? 10 : 3;
    inw = d * 256;
    res = '0;
    for (int i = 0; i < 256; i++) begin
      x = 0;
      for (int k = 0; k < d; k++) begin
        s = d * i + k;
        if (comp[inw - 8 - 8 * (s / 8) + (s % 8)]) x += (1 << k);
      end
      y = (x * 3329 + (1 << (d - 1))) >> d;
      res[12*i +: 12] = 12'(y);
    end
    return res;
  endfunction

  function automatic logic [2559:0] rand_comp(input bit d10);
    logic [2559:0] v;
    v = '0;
    for (int j = 0; j < (d10 ? 320 : 96); j++) v[8*j +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic push_exp(input bit d10, input logic [PW_W-1:0] e);
    if (d10) exp_q10.push_back(e);
    else exp_q3.push_back(e);
  endtask

  task automatic sb_check(input bit d10, input string name);
    logic [PW_W-1:0] e;
    if (d10 ? (exp_q10.size() == 0) : (exp_q3.size() == 0)) begin
      chk_int({name, "_sb_empty"}, 1, 0);
    end else begin
      e = d10 ? exp_q10.pop_front() : exp_q3.pop_front();
      chk_poly(name, d10 ? poly10 : poly3, e);
    end
  endtask

  // Drives a start at a negedge; returns 1 ns after the start edge.
  task automatic start_run(input bit d10, input logic [2559:0] comp, input bit hold_en);
    @(negedge clk);
    if (d10) begin comp10 = comp; en10 = 1'b1; end
    else begin comp3 = comp[767:0]; en3 = 1'b1; end
    @(posedge clk); #1;
    if (!hold_en) begin en3 = 1'b0; en10 = 1'b0; end
  endtask

  // Counts edges after the start edge until done is seen, then checks the pulse is one cycle wide.
  task automatic wait_done(input bit d10, input string name);
    int lat;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (d10 ? done10 : done3) begin lat = c; break; end
    end
    chk_int({name, "_latency"}, lat, G);
    @(posedge clk); #1;
    chk_int({name, "_done_width"}, int'(d10 ? done10 : done3), 0);
  endtask

  vec_t tbl[8];

  initial begin
    logic [2559:0] v, v2;
    logic [PW_W-1:0] e;
    int pulses, bad;

    reset_n = 1'b0; en3 = 1'b0; en10 = 1'b0; comp3 = '0; comp10 = '0;

    v = '0;
    tbl[0] = '{1'b0, v, 0, 12'd0, 12'd0};
    v = '0; v[767:0] = '1;
    tbl[1] = '{1'b0, v, 0, 12'd2913, 12'd2913};
    v = '0; v[767:760] = 8'h01;
    tbl[2] = '{1'b0, v, 0, 12'd416, 12'd0};
    v = '0; v[5] = 1'b1; v[7] = 1'b1;
    tbl[3] = '{1'b0, v, 255, 12'd2081, 12'd0};
    v = '0; v[2559:2544] = 16'hFF03;
    tbl[4] = '{1'b1, v, 0, 12'd3326, 12'd0};
    v = '1;
    tbl[5] = '{1'b1, v, 0, 12'd3326, 12'd3326};
    v = '0; v[14] = 1'b1;
    tbl[6] = '{1'b1, v, 255, 12'd3, 12'd0};
    v = '0; v[2539] = 1'b1;
    tbl[7] = '{1'b1, v, 1, 12'd1665, 12'd0};

    repeat (3) @(posedge clk);
    #1;
    chk_int("reset_done3", int'(done3), 0);
    chk_int("reset_done10", int'(done10), 0);
    chk_poly("reset_poly3", poly3, '0);
    chk_poly("reset_poly10", poly10, '0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) e[12*i +: 12] = (i == tbl[t].sel_idx) ? tbl[t].sel_val : tbl[t].rest_val;
      push_exp(tbl[t].d10, e);
      start_run(tbl[t].d10, tbl[t].comp, 1'b0);
      wait_done(tbl[t].d10, $sformatf("tbl%0d", t));
      sb_check(tbl[t].d10, $sformatf("tbl%0d_poly", t));
    end

    for (int r = 0; r < 6; r++) begin
      bit d10;
      d10 = r[0];
      v = rand_comp(d10);
      push_exp(d10, model(d10, v));
      start_run(d10, v, 1'b0);
      wait_done(d10, $sformatf("rnd%0d", r));
      sb_check(d10, $sformatf("rnd%0d_poly", r));
    end

    // Held enable with an input change mid-run: one done, latched data, then stable output.
    v = rand_comp(1'b1);
    e = model(1'b1, v);
    push_exp(1'b1, e);
    start_run(1'b1, v, 1'b1);
    pulses = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == 5) comp10 = ~comp10;
      if (done10) pulses++;
    end
    chk_int("held_en_pulses", pulses, 1);
    sb_check(1'b1, "held_en_poly");
    en10 = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      comp10 = rand_comp(1'b1);
      if (poly10 !== e || done10) bad++;
    end
    chk_int("hold_stable", bad, 0);

    // Reset mid-run aborts and clears; a fresh run afterwards completes normally.
    start_run(1'b1, rand_comp(1'b1), 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_int("abort_done", int'(done10), 0);
    chk_poly("abort_poly10", poly10, '0);
    chk_poly("abort_poly3", poly3, '0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done10) pulses++;
    end
    chk_int("abort_no_done", pulses, 0);
    @(negedge clk);
    reset_n = 1'b1;
    v = rand_comp(1'b1);
    push_exp(1'b1, model(1'b1, v));
    start_run(1'b1, v, 1'b0);
    wait_done(1'b1, "post_reset");
    sb_check(1'b1, "post_reset_poly");

    // Back-to-back on the D=3 unit: enable dropped for a single cycle between runs.
    v = rand_comp(1'b0);
    v2 = rand_comp(1'b0);
    push_exp(1'b0, model(1'b0, v));
    start_run(1'b0, v, 1'b1);
    wait_done(1'b0, "b2b_first");
    sb_check(1'b0, "b2b_first_poly");
    @(negedge clk);
    en3 = 1'b0;
    @(negedge clk);
    en3 = 1'b1;
    comp3 = v2[767:0];
    push_exp(1'b0, model(1'b0, v2));
    @(posedge clk); #1;
    en3 = 1'b0;
    wait_done(1'b0, "b2b_second");
    sb_check(1'b0, "b2b_second_poly");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
